// File: rtl/reg_bank_arbiter_pkg.sv
// reg_bank_arbiter_pkg
//   Types and helpers shared by the register-bank arbiter.
//   - arb_state_t : arbiter FSM encoding (IDLE=0, GRANT=1, LOCK=2)
//   - rr_winner() : round-robin one-hot winner of a request vector,
//                   searching upward from a pointer, modulo n (n <= 8)
package reg_bank_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_LOCK  = 2'd2
   } arb_state_t;

   localparam int unsigned NREQ_MAX = 8;

   // Scans p, p+1, ..., p-1 (mod n) and returns the first requester set,
   // one-hot. Bits at or above n are never selected.
   function automatic logic [NREQ_MAX-1:0] rr_winner(
      input logic [NREQ_MAX-1:0] req,
      input logic [2:0]          ptr,
      input int unsigned         n
   );
      logic [NREQ_MAX-1:0] win;
      logic [2:0]          idx;
      logic                found;
      win   = '0;
      found = 1'b0;
      idx   = ptr;
      for (int unsigned i = 0; i < NREQ_MAX; i++) begin
         if ((i < n) && !found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
         idx = ((32'(idx) + 32'd1) >= n) ? 3'd0 : idx + 3'd1;
      end
      return win;
   endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_picker.sv
// reg_bank_arbiter_rr_picker
//   Combinational round-robin picker: rotates the request vector so the
//   pointer position lands on bit 0, keeps the lowest set bit, then
//   rotates the result back.
//   Ports:
//     req  in  NREQ    request vector
//     ptr  in  PWIDTH  highest-priority requester index (0..NREQ-1)
//     gnt  out NREQ    one-hot winner, zero when no request
module reg_bank_arbiter_rr_picker #(
   parameter int NREQ   = 4,
   parameter int PWIDTH = 2
) (
   input  logic [NREQ-1:0]   req,
   input  logic [PWIDTH-1:0] ptr,
   output logic [NREQ-1:0]   gnt
);

   localparam logic [PWIDTH:0] N_P = (PWIDTH + 1)'(NREQ);

   logic [NREQ-1:0]   req_rot;
   logic [NREQ-1:0]   pick_rot;
   logic [PWIDTH:0]   back_amt;

   assign req_rot  = NREQ'({req, req} >> ptr);
   // Two's-complement trick isolates the lowest set bit.
   assign pick_rot = req_rot & (~req_rot + NREQ'(1));
   // Rotating right by NREQ-ptr is the same as rotating left by ptr;
   // ptr == 0 gives a shift of NREQ, whose low half is the input itself.
   assign back_amt = N_P - {1'b0, ptr};
   assign gnt      = NREQ'({pick_rot, pick_rot} >> back_amt);

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
//   Shared register bank with round-robin write arbitration among NREQ
//   masters and one combinational read port.
//   Optional feature: define REG_BANK_ARBITER_LOCK_EN to let the owner hold
//   the grant across consecutive transfers using i_lock.
//   Ports:
//     i_clk    in  1            clock, rising edge
//     i_rst    in  1            asynchronous active-high reset
//     i_req    in  NREQ         per-requester write request
//     i_addr   in  NREQ*AWIDTH  packed write addresses, k at [k*AWIDTH +: AWIDTH]
//     i_wdata  in  NREQ*DWIDTH  packed write data, same packing
//     i_lock   in  NREQ         burst lock (ignored unless lock build)
//     o_gnt    out NREQ         registered one-hot grant
//     i_raddr  in  AWIDTH       read address
//     o_rdata  out DWIDTH       bank[i_raddr], combinational
//     o_busy   out 1            registered, equals |o_gnt
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no grant; arbitrate from the stored pointer
//   ST_GRANT | o_gnt one-hot to owner; pointer moves past owner each edge
//   ST_LOCK  | owner keeps grant, pointer frozen (lock build only)
module reg_bank_arbiter
   import reg_bank_arbiter_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int DEPTH  = 8,
   parameter int DWIDTH = 8,
   parameter int AWIDTH = $clog2(DEPTH)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NREQ-1:0]          i_req,
   input  logic [NREQ*AWIDTH-1:0]   i_addr,
   input  logic [NREQ*DWIDTH-1:0]   i_wdata,
   input  logic [NREQ-1:0]          i_lock,
   output logic [NREQ-1:0]          o_gnt,
   input  logic [AWIDTH-1:0]        i_raddr,
   output logic [DWIDTH-1:0]        o_rdata,
   output logic                     o_busy
);

   localparam int PWIDTH = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t        state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d, rr_gnt;
   logic [PWIDTH-1:0] ptr_q, ptr_d, arb_ptr;
   logic [PWIDTH-1:0] owner_idx, owner_next;
   logic              busy_q;
   logic              xfer;
   logic [AWIDTH-1:0] owner_addr;
   logic [DWIDTH-1:0] owner_wdata;
   logic [DWIDTH-1:0] bank_q [DEPTH];

   // Owner index and payload mux, driven by the registered grant.
   always_comb begin
      owner_idx   = '0;
      owner_addr  = '0;
      owner_wdata = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_q[k]) begin
            owner_idx   = PWIDTH'(k);
            owner_addr  = i_addr[k*AWIDTH +: AWIDTH];
            owner_wdata = i_wdata[k*DWIDTH +: DWIDTH];
         end
      end
   end

   assign owner_next = (owner_idx == PWIDTH'(NREQ - 1)) ? '0 : owner_idx + PWIDTH'(1);
   assign xfer       = |(i_req & gnt_q);

`ifdef REG_BANK_ARBITER_LOCK_EN
   logic owner_lock;
   assign owner_lock = |(i_lock & gnt_q);
`else
   logic unused_lock;
   assign unused_lock = ^i_lock;
`endif

   // When a grant is being released the search already starts past the
   // current owner, so back-to-back grants see the advanced pointer.
   assign arb_ptr = (state_q == ST_IDLE) ? ptr_q : owner_next;

   reg_bank_arbiter_rr_picker #(
      .NREQ   (NREQ),
      .PWIDTH (PWIDTH)
   ) u_rr_picker (
      .req (i_req),
      .ptr (arb_ptr),
      .gnt (rr_gnt)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (|i_req) begin
               state_d = ST_GRANT;
               gnt_d   = rr_gnt;
            end else begin
               gnt_d = '0;
            end
         end
`ifdef REG_BANK_ARBITER_LOCK_EN
         ST_GRANT, ST_LOCK: begin
`else
         ST_GRANT: begin
`endif
`ifdef REG_BANK_ARBITER_LOCK_EN
            if (xfer && owner_lock) begin
               state_d = ST_LOCK;
            end else
`endif
            begin
               // A dropped request advances the pointer just like a
               // completed transfer so the owner cannot starve others.
               ptr_d = owner_next;
               if (|i_req) begin
                  state_d = ST_GRANT;
                  gnt_d   = rr_gnt;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         busy_q  <= |gnt_d;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            bank_q[i] <= '0;
         end
      end else if (xfer) begin
         bank_q[owner_addr] <= owner_wdata;
      end
   end

   assign o_gnt   = gnt_q;
   assign o_busy  = busy_q;
   assign o_rdata = bank_q[i_raddr];

endmodule

// File: tb/tb_reg_bank_arbiter.sv
module tb_reg_bank_arbiter;

   localparam int N  = 4;
   localparam int D  = 8;
   localparam int W  = 8;
   localparam int AW = 3;
`ifdef REG_BANK_ARBITER_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req, lock, gnt;
   logic [N*AW-1:0] addr;
   logic [N*W-1:0]  wdata;
   logic [AW-1:0]   raddr;
   logic [W-1:0]    rdata;
   logic            busy;

   logic [AW-1:0]   p_addr [N];
   logic [W-1:0]    p_data [N];

   // Reference: owner index (-1 = none), next-search pointer, bank contents.
   logic [W-1:0]    m_bank [D];
   int              m_owner, m_ptr, last_xfer;
   int              total = 0;
   int              bad   = 0;

   reg_bank_arbiter #(.NREQ(N), .DEPTH(D), .DWIDTH(W)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_req   (req),
      .i_addr  (addr),
      .i_wdata (wdata),
      .i_lock  (lock),
      .o_gnt   (gnt),
      .i_raddr (raddr),
      .o_rdata (rdata),
      .o_busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int pick();
      for (int i = 0; i < N; i++) begin
         int idx;
         idx = (m_ptr + i) % N;
         if (req[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_gnt();
      return (m_owner < 0) ? '0 : N'(1 << m_owner);
   endfunction

   task automatic model_reset();
      m_owner   = -1;
      m_ptr     = 0;
      last_xfer = -1;
      for (int a = 0; a < D; a++) m_bank[a] = '0;
   endtask

   // Drive packed payloads, advance one edge, update the model, then
   // compare grant, busy and the read port just after the edge.
   task automatic tick();
      for (int k = 0; k < N; k++) begin
         addr[k*AW +: AW] = p_addr[k];
         wdata[k*W +: W]  = p_data[k];
      end
      @(posedge clk);
      last_xfer = -1;
      if (m_owner >= 0) begin
         if (req[m_owner]) begin
            m_bank[p_addr[m_owner]] = p_data[m_owner];
            last_xfer = m_owner;
         end
         if (!(LOCK_EN && req[m_owner] && lock[m_owner])) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = pick();
         end
      end else begin
         m_owner = pick();
      end
      #1;
      check("gnt", 32'(gnt), 32'(exp_gnt()));
      check("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
      check("rdata", 32'(rdata), 32'(m_bank[raddr]));
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req  = '0;
      lock = '0;
      model_reset();
      #2;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      for (int a = 0; a < D; a++) begin
         raddr = AW'(a);
         #1;
         check("rst_rdata", 32'(rdata), 32'd0);
      end
      rst = 1'b0;
   endtask

   initial begin
      int seq_rr [5];
      int seq_lk [5];
      rst   = 1'b1;
      req   = '0;
      lock  = '0;
      raddr = '0;
      for (int k = 0; k < N; k++) begin
         p_addr[k] = '0;
         p_data[k] = '0;
      end
      addr  = '0;
      wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Single requester: grant one cycle later, data visible after transfer.
      req[0] = 1'b1; p_addr[0] = 3'd3; p_data[0] = 8'hA5; raddr = 3'd3;
      tick();
      check("single_gnt", 32'(gnt), 32'h1);
      check("single_old", 32'(rdata), 32'h0);
      tick();
      check("single_rd", 32'(rdata), 32'hA5);
      req = '0;
      tick(); tick();

      // Reset while a transfer is pending discards it.
      req[1] = 1'b1; p_addr[1] = 3'd2; p_data[1] = 8'hFF; raddr = 3'd2;
      tick();
      do_reset();
      tick();

      // Full contention: strict rotation with no idle cycle.
      seq_rr = '{1, 2, 4, 8, 1};
      for (int k = 0; k < N; k++) begin
         p_addr[k] = AW'(k + 4);
         p_data[k] = W'(8'h10 + k);
      end
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         raddr = AW'(4 + (i % N));
         tick();
         check("rr_seq", 32'(gnt), 32'(seq_rr[i]));
      end
      req = '0;
      tick(); tick();

      // Wrap and skip: pointer reaches 3, requests 0 and 2.
      do_reset();
      req = 4'b0100; p_addr[2] = 3'd1; p_data[2] = 8'h21;
      tick();
      req = 4'b0101; p_addr[0] = 3'd0; p_data[0] = 8'h30;
      tick();
      check("wrap_gnt0", 32'(gnt), 32'h1);
      tick();
      check("wrap_gnt2", 32'(gnt), 32'h4);
      req = '0;
      tick(); tick();

      // Withdraw while granted: no write, grant moves on.
      do_reset();
      req = 4'b0010; p_addr[1] = 3'd5; p_data[1] = 8'h3C; raddr = 3'd5;
      tick();
      check("wd_gnt1", 32'(gnt), 32'h2);
      req = 4'b0100; p_addr[2] = 3'd6; p_data[2] = 8'h77;
      tick();
      check("wd_gnt2", 32'(gnt), 32'h4);
      check("wd_nowrite", 32'(rdata), 32'h0);
      raddr = 3'd6;
      tick();
      check("wd_rd2", 32'(rdata), 32'h77);
      req = '0;
      tick(); tick();

      // Lock burst by requester 2 while everyone requests.
`ifdef REG_BANK_ARBITER_LOCK_EN
      seq_lk = '{4, 4, 4, 4, 8};
`else
      seq_lk = '{4, 8, 1, 2, 4};
`endif
      do_reset();
      for (int k = 0; k < N; k++) begin
         p_addr[k] = AW'(k);
         p_data[k] = W'(8'h50 + k);
      end
      req = 4'b0100; lock = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) req = 4'b1111;
         if (i == 4) lock = '0;
         if (i >= 1) p_data[2] = W'(8'h60 + i);
         raddr = 3'd2;
         tick();
         check("lock_seq", 32'(gnt), 32'(seq_lk[i]));
      end
      req = '0; lock = '0;
      tick(); tick();

      // Random traffic against the reference.
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int k = 0; k < N; k++) begin
            if (k == last_xfer) begin
               if ($urandom_range(0, 1) == 0) begin
                  req[k] = 1'b0;
               end else begin
                  p_addr[k] = AW'($urandom_range(0, D - 1));
                  p_data[k] = W'($urandom);
               end
            end else if (!req[k]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req[k]    = 1'b1;
                  p_addr[k] = AW'($urandom_range(0, D - 1));
                  p_data[k] = W'($urandom);
               end
            end else if (k == m_owner && $urandom_range(0, 7) == 0) begin
               req[k] = 1'b0;
            end
         end
         lock  = N'($urandom);
         raddr = AW'($urandom_range(0, D - 1));
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Shared register-bank controller: arbitrates write access to a bank of edge-triggered storage registers among NREQ requesters using round-robin priority and a valid/grant handshake. It sits between several write masters and a single flip-flop array, and presents one combinational read port. It is the first multi-master sequencing block built on the flip-flop primitives of the sequential-logic set.

## Interface
Parameters:
- NREQ, 4, number of write requesters (2..8)
- DEPTH, 8, registers in the bank (power of two)
- DWIDTH, 8, bits per register
- AWIDTH, $clog2(DEPTH), address width (derived; do not override)

Ports:
- i_clk  in  1  single clock, all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_req  in  NREQ  per-requester write request
- i_addr  in  NREQ*AWIDTH  packed write addresses, requester k at [k*AWIDTH +: AWIDTH]
- i_wdata  in  NREQ*DWIDTH  packed write data, same packing
- i_lock  in  NREQ  per-requester burst lock (used only with LOCK_EN)
- o_gnt  out  NREQ  registered one-hot grant
- i_raddr  in  AWIDTH  read address
- o_rdata  out  DWIDTH  bank[i_raddr], combinational
- o_busy  out  1  registered, high while any grant is asserted

## Operation
- Reset: all bank registers 0, o_gnt 0, o_busy 0, round-robin pointer 0, FSM IDLE.
- FSM states: IDLE (no grant), GRANT (o_gnt one-hot to owner), LOCK (owner held; LOCK_EN only).
- IDLE: if any i_req, next cycle GRANT to the winner; otherwise stay.
- Winner: first requester with i_req set, searching from pointer p upward modulo NREQ (p, p+1, ..., p-1).
- GRANT: transfer when i_req[k] && o_gnt[k] at the clock edge; bank[i_addr_k] <= i_wdata_k. Pointer becomes owner+1 (mod NREQ, wraps NREQ-1 -> 0). On the same edge, arbitration re-runs over current i_req with the updated pointer:
  - any request present -> GRANT to the new winner (back-to-back grants, no idle bubble);
  - none -> IDLE.
- Owner drops i_req while granted: no write; grant released the next cycle; pointer advances as if the transfer occurred (no starvation).
- A requester holds i_req, address and data stable until it sees o_gnt[k] high at a clock edge.
- Only the granted requester's payload is ever written; other i_addr/i_wdata values are ignored.
- Read is combinational; a write is visible on o_rdata the cycle after the transfer edge. Same-cycle read of the address being written returns the old value.
- Reset mid-transfer: the write is discarded, all state returns to reset values immediately (asynchronous).

## Timing
- Request to grant: 1 cycle (i_req high at edge n -> o_gnt at edge n+1 when idle).
- Grant to write: the transfer occurs on the edge at which o_gnt and i_req are both high; data is in the bank after that edge.
- Sustained throughput: one write per cycle while requests are pending.
- Worst-case wait under full contention: NREQ grant cycles.
- o_busy == |o_gnt at all times.

## Configuration
- Macro: REG_BANK_ARBITER_LOCK_EN.
- Defined:
  - if the owner transfers with i_lock[owner]=1, the FSM enters LOCK;
  - the pointer does not advance and the grant stays with the owner;
  - each further transfer writes normally;
  - the transfer with i_lock=0 (or the owner dropping i_req) returns to normal arbitration.
- Undefined: the LOCK state and the i_lock logic are not compiled; the i_lock port remains and is ignored.

## Structure
- Shared package holds the FSM state encoding (IDLE=2'd0, GRANT=2'd1, LOCK=2'd2) and a function computing a round-robin one-hot winner from (req, pointer).
- One sub-module is natural: rr_picker (combinational rotate / priority-select / rotate-back). The bank and FSM live in the top.

## Test plan
- Reset: drive i_rst=1 mid-run -> o_gnt=0, o_busy=0, every o_rdata=0 across all 8 addresses.
- Single requester: i_req=4'b0001, addr 3, data 8'hA5 -> o_gnt=4'b0001 one cycle later; o_rdata at addr 3 = 8'hA5 the cycle after the transfer.
- Full contention: i_req=4'b1111 held, distinct addr/data -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; no bubble.
- Wrap and skip: pointer=3, i_req=4'b0101 -> grant 0001, then 0100.
- Requester withdraws: requester 1 drops i_req while granted -> no write to its address; grant moves to the next requester.
- LOCK_EN: requester 2 with i_lock=1 for 3 transfers while others request -> o_gnt=4'b0100 for 4 consecutive transfers, then round-robin resumes at requester 3. Without the macro: plain rotation.
